// File: rtl/score_bcd_accum_pkg.sv
// Shared definitions for the BCD score accumulator.
//   - FSM state encoding (IDLE, ADD0, ADD1, ADD2, COMMIT)
//   - BCD digit limit
//   - helper that folds unsupported line counts (5..7) to zero
package score_bcd_accum_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADD0   = 3'd1;
    localparam logic [2:0] ST_ADD1   = 3'd2;
    localparam logic [2:0] ST_ADD2   = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam logic [3:0] BCD_NINE  = 4'd9;

    // The playfield never clears more than four lines at once; anything
    // above that is treated as an empty event.
    function automatic logic [2:0] lines_eff(input logic [2:0] n);
        return (n > 3'd4) ? 3'd0 : n;
    endfunction

endpackage

// File: rtl/score_bcd_accum_bcd_digit_add.sv
// Single-digit BCD adder (combinational).
//   a, b  : BCD digits (0..9)
//   cin   : carry in from the lower digit
//   sum   : corrected BCD sum digit
//   cout  : carry out to the next digit
module bcd_digit_add
    import score_bcd_accum_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw_sum;

    always_comb begin
        raw_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw_sum > {1'b0, BCD_NINE}) begin
            // Decimal overflow: wrap the digit and carry into the next one.
            sum  = 4'(raw_sum - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = raw_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_bcd_accum.sv
// Tetris score keeper: accepts line-clear events, adds the point value for
// the event to a 3-digit BCD score with one time-multiplexed digit adder,
// saturates at 999 and tracks the level.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active low
//   new_game   synchronous clear of score/level/line count/sat, aborts adds
//   clr_valid  line-clear event valid (held until accepted)
//   clr_lines  lines cleared in the event (0..4, 5..7 count as 0)
//   clr_ready  high while idle and able to take an event
//   dig2..dig0 score hundreds/tens/ones (BCD), to the display scanner
//   level      current level, 0..MAX_LEVEL
//   score_upd  one-cycle pulse after each commit
//   sat        sticky flag: score saturated at 999
// The score registers only change at commit, so the display never sees a
// half-finished sum.
module score_bcd_accum
    import score_bcd_accum_pkg::*;
#(
    parameter logic [7:0] PTS1            = 8'h01,
    parameter logic [7:0] PTS2            = 8'h03,
    parameter logic [7:0] PTS3            = 8'h05,
    parameter logic [7:0] PTS4            = 8'h08,
    parameter logic [3:0] LINES_PER_LEVEL = 4'd10,
    parameter logic [3:0] MAX_LEVEL       = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       clr_valid,
    input  logic [2:0] clr_lines,
    output logic       clr_ready,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic [3:0] level,
    output logic       score_upd,
    output logic       sat
);

    logic [2:0]  state_reg;
    logic [11:0] score_reg;
    logic [11:0] work_bus;
    logic [7:0]  pts_reg;
    logic [2:0]  lines_reg;
    logic        carry_reg;
    logic [3:0]  line_cnt_reg;
    logic [3:0]  level_reg;
    logic        sat_reg;
    logic        upd_reg;

    logic        accept;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_sum;
    logic        add_cout;
    logic [4:0]  cnt_sum;
    logic [3:0]  line_cnt_next;
    logic [3:0]  level_next;

    function automatic logic [7:0] pts_for(input logic [2:0] n);
        case (n)
            3'd1:    return PTS1;
            3'd2:    return PTS2;
            3'd3:    return PTS3;
            3'd4:    return PTS4;
            default: return 8'h00;
        endcase
    endfunction

    // new_game wins over a same-cycle event.
    assign accept = (state_reg == ST_IDLE) && clr_valid && !new_game;

    // Per-digit work registers: loaded from the score on accept, then each
    // one is overwritten by the shared adder in its own ADD state.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_work
            localparam logic [2:0] ADD_ST = 3'(ST_ADD0 + gi);
            logic [3:0] work_reg;

            always_ff @(posedge clk) begin
                if (accept) begin
                    work_reg <= score_reg[gi*4 +: 4];
                end else if (state_reg == ADD_ST) begin
                    work_reg <= add_sum;
                end
            end

            assign work_bus[gi*4 +: 4] = work_reg;
        end
    endgenerate

    // Route the digit being worked on through the single adder. The hundreds
    // digit of the point value is always zero.
    always_comb begin
        add_a = 4'd0;
        add_b = 4'd0;
        case (state_reg)
            ST_ADD0: begin
                add_a = work_bus[3:0];
                add_b = pts_reg[3:0];
            end
            ST_ADD1: begin
                add_a = work_bus[7:4];
                add_b = pts_reg[7:4];
            end
            ST_ADD2: begin
                add_a = work_bus[11:8];
                add_b = 4'd0;
            end
            default: begin
                add_a = 4'd0;
                add_b = 4'd0;
            end
        endcase
    end

    bcd_digit_add u_digit_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Line count stays below LINES_PER_LEVEL (<=15) and an event adds at most
    // four, so one subtraction is always enough.
    always_comb begin
        cnt_sum       = {1'b0, line_cnt_reg} + {2'b00, lines_reg};
        line_cnt_next = cnt_sum[3:0];
        level_next    = level_reg;
        if (cnt_sum >= {1'b0, LINES_PER_LEVEL}) begin
            line_cnt_next = 4'(cnt_sum - {1'b0, LINES_PER_LEVEL});
            if (level_reg < MAX_LEVEL) begin
                level_next = level_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || new_game) begin
            state_reg    <= ST_IDLE;
            score_reg    <= 12'h000;
            pts_reg      <= 8'h00;
            lines_reg    <= 3'd0;
            carry_reg    <= 1'b0;
            line_cnt_reg <= 4'd0;
            level_reg    <= 4'd0;
            sat_reg      <= 1'b0;
            upd_reg      <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (clr_valid) begin
                        pts_reg   <= pts_for(lines_eff(clr_lines));
                        lines_reg <= lines_eff(clr_lines);
                        carry_reg <= 1'b0;
                        state_reg <= ST_ADD0;
                    end
                end
                ST_ADD0: begin
                    carry_reg <= add_cout;
                    state_reg <= ST_ADD1;
                end
                ST_ADD1: begin
                    carry_reg <= add_cout;
                    state_reg <= ST_ADD2;
                end
                ST_ADD2: begin
                    carry_reg <= add_cout;
                    state_reg <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // A carry out of the hundreds digit means the true score
                    // passed 999; once saturated the score is pinned there.
                    if (carry_reg || sat_reg) begin
                        score_reg <= 12'h999;
                        sat_reg   <= 1'b1;
                    end else begin
                        score_reg <= work_bus;
                    end
                    line_cnt_reg <= line_cnt_next;
                    level_reg    <= level_next;
                    upd_reg      <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign clr_ready = (state_reg == ST_IDLE);
    assign dig2      = score_reg[11:8];
    assign dig1      = score_reg[7:4];
    assign dig0      = score_reg[3:0];
    assign level     = level_reg;
    assign score_upd = upd_reg;
    assign sat       = sat_reg;

endmodule

// File: tb/tb_score_bcd_accum.sv
// Directed testbench for score_bcd_accum. Inputs change on the falling edge,
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_score_bcd_accum;

    logic       clk;
    logic       rst;
    logic       new_game;
    logic       clr_valid;
    logic [2:0] clr_lines;
    logic       clr_ready;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic [3:0] level;
    logic       score_upd;
    logic       sat;

    int checks;
    int passed;

    score_bcd_accum dut (
        .clk       (clk),
        .rst       (rst),
        .new_game  (new_game),
        .clr_valid (clr_valid),
        .clr_lines (clr_lines),
        .clr_ready (clr_ready),
        .dig2      (dig2),
        .dig1      (dig1),
        .dig0      (dig0),
        .level     (level),
        .score_upd (score_upd),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one event, wait for acceptance (bounded), and return on the
    // falling edge after the commit edge, when the new score is visible.
    task automatic run_event(input logic [2:0] n);
        int k;
        @(negedge clk);
        clr_valid = 1'b1;
        clr_lines = n;
        k = 0;
        while (!clr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 20) $display("FAIL accept_timeout got ready=%b need ready=1", clr_ready);
        else passed++;
        @(negedge clk);
        clr_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; new_game = 1'b0; clr_valid = 1'b0; clr_lines = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dig2, dig1, dig0} !== 12'h000) $display("FAIL reset_score got %h need 000", {dig2, dig1, dig0});
        else passed++;
        checks++;
        if ({level, sat, score_upd, clr_ready} !== 7'b0000_001)
            $display("FAIL reset_flags got level=%0d sat=%b upd=%b ready=%b need 0 0 0 1", level, sat, score_upd, clr_ready);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (clr_ready !== 1'b1) $display("FAIL reset_release_ready got %b need 1", clr_ready);
        else passed++;
    endtask

    task automatic test_first_event();
        int low_cnt;
        int upd_cnt;
        low_cnt = 0; upd_cnt = 0;
        @(negedge clk);
        clr_valid = 1'b1;
        clr_lines = 3'd4;
        @(negedge clk);
        clr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!clr_ready) low_cnt++;
            if (score_upd) upd_cnt++;
            checks++;
            if ({dig2, dig1, dig0} !== 12'h000) $display("FAIL busy_score_stable got %h need 000", {dig2, dig1, dig0});
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (low_cnt !== 4) $display("FAIL busy_ready_low got %0d cycles need 4", low_cnt);
        else passed++;
        checks++;
        if (upd_cnt !== 0) $display("FAIL busy_no_upd got %0d pulses need 0", upd_cnt);
        else passed++;
        checks++;
        if ({dig2, dig1, dig0} !== 12'h008) $display("FAIL first_sum got %h need 008", {dig2, dig1, dig0});
        else passed++;
        checks++;
        if ({score_upd, clr_ready} !== 2'b11) $display("FAIL commit_flags got upd=%b ready=%b need 1 1", score_upd, clr_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (score_upd !== 1'b0) $display("FAIL upd_single_pulse got %b need 0", score_upd);
        else passed++;
    endtask

    task automatic test_carry();
        pulse_new_game();
        run_event(3'd3); run_event(3'd1); run_event(3'd1);
        checks++;
        if ({dig2, dig1, dig0} !== 12'h007) $display("FAIL build_007 got %h need 007", {dig2, dig1, dig0});
        else passed++;
        run_event(3'd4);
        checks++;
        if ({dig2, dig1, dig0} !== 12'h015) $display("FAIL add_007_8 got %h need 015", {dig2, dig1, dig0});
        else passed++;
        pulse_new_game();
        for (int i = 0; i < 12; i++) run_event(3'd4);
        run_event(3'd1);
        checks++;
        if ({dig2, dig1, dig0} !== 12'h097) $display("FAIL build_097 got %h need 097", {dig2, dig1, dig0});
        else passed++;
        run_event(3'd3);
        checks++;
        if ({dig2, dig1, dig0} !== 12'h102) $display("FAIL ripple_097_5 got %h need 102", {dig2, dig1, dig0});
        else passed++;
    endtask

    task automatic test_saturate();
        pulse_new_game();
        for (int i = 0; i < 124; i++) run_event(3'd4);
        run_event(3'd2);
        checks++;
        if ({dig2, dig1, dig0, sat} !== 13'h995 << 1) $display("FAIL build_995 got %h sat=%b need 995 sat=0", {dig2, dig1, dig0}, sat);
        else passed++;
        run_event(3'd4);
        checks++;
        if ({dig2, dig1, dig0} !== 12'h999) $display("FAIL saturate_score got %h need 999", {dig2, dig1, dig0});
        else passed++;
        checks++;
        if (sat !== 1'b1) $display("FAIL saturate_flag got %b need 1", sat);
        else passed++;
        run_event(3'd1);
        checks++;
        if ({dig2, dig1, dig0, sat} !== {12'h999, 1'b1}) $display("FAIL saturate_hold got %h sat=%b need 999 sat=1", {dig2, dig1, dig0}, sat);
        else passed++;
    endtask

    task automatic test_level();
        pulse_new_game();
        checks++;
        if ({sat, level} !== 5'd0) $display("FAIL new_game_clear got sat=%b level=%0d need 0 0", sat, level);
        else passed++;
        for (int i = 0; i < 9; i++) run_event(3'd1);
        checks++;
        if (level !== 4'd0) $display("FAIL level_after_9 got %0d need 0", level);
        else passed++;
        run_event(3'd1);
        checks++;
        if (level !== 4'd1) $display("FAIL level_after_10 got %0d need 1", level);
        else passed++;
        for (int i = 10; i < 89; i++) run_event(3'd1);
        checks++;
        if (level !== 4'd8) $display("FAIL level_after_89 got %0d need 8", level);
        else passed++;
        for (int i = 89; i < 100; i++) run_event(3'd1);
        checks++;
        if (level !== 4'd9) $display("FAIL level_cap got %0d need 9", level);
        else passed++;
        checks++;
        if ({dig2, dig1, dig0} !== 12'h100) $display("FAIL score_after_100 got %h need 100", {dig2, dig1, dig0});
        else passed++;
    endtask

    task automatic test_abort();
        int upd_cnt;
        int bad_score;
        upd_cnt = 0; bad_score = 0;
        @(negedge clk);
        clr_valid = 1'b1;
        clr_lines = 3'd4;
        @(negedge clk);
        clr_valid = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        checks++;
        if ({dig2, dig1, dig0, level} !== 16'h0000) $display("FAIL abort_clear got %h level=%0d need 000 0", {dig2, dig1, dig0}, level);
        else passed++;
        checks++;
        if ({clr_ready, score_upd} !== 2'b10) $display("FAIL abort_flags got ready=%b upd=%b need 1 0", clr_ready, score_upd);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            if (score_upd) upd_cnt++;
            if ({dig2, dig1, dig0} !== 12'h000) bad_score++;
            @(negedge clk);
        end
        checks++;
        if (upd_cnt !== 0 || bad_score !== 0) $display("FAIL abort_no_commit got upd=%0d bad=%0d need 0 0", upd_cnt, bad_score);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int ready_cnt;
        int upd_cnt;
        ready_cnt = 0; upd_cnt = 0;
        run_event(3'd2);
        @(negedge clk);
        clr_valid = 1'b1;
        clr_lines = 3'd0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) clr_lines = 3'd6;
            if (clr_ready) ready_cnt++;
            if (score_upd) upd_cnt++;
            @(negedge clk);
        end
        clr_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (ready_cnt !== 4) $display("FAIL held_valid_ready got %0d need 4", ready_cnt);
        else passed++;
        checks++;
        if (upd_cnt !== 3) $display("FAIL held_valid_commits got %0d need 3", upd_cnt);
        else passed++;
        checks++;
        if ({dig2, dig1, dig0, level} !== 16'h0030) $display("FAIL zero_point_events got %h level=%0d need 003 0", {dig2, dig1, dig0}, level);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_first_event();
        test_carry();
        test_saturate();
        test_level();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
